// File: rtl/riscv_lsu.sv
// riscv_lsu: memory stage of the my_riscv pipeline.
// Passes ALU results through to writeback, or runs a single load/store over a
// req/ready + rvalid data-memory handshake with byte-lane alignment and
// sign/zero extension. Upstream is stalled while an access is outstanding.
module riscv_lsu #(
  parameter logic [6:0] OP_LOAD  = 7'b0000011,
  parameter logic [6:0] OP_STORE = 7'b0100011
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_alu_num,
  input  logic [31:0] i_store_data,
  input  logic [4:0]  i_rd,
  input  logic        i_rd_we,
  output logic        o_stall,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic        i_mem_ready,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_valid,
  output logic [31:0] o_wb_data,
  output logic [4:0]  o_rd,
  output logic        o_wb_en,
  output logic        o_fault
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e      state_q, state_d;

  // Memory-side request registers (held stable for the whole REQ phase)
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        mem_we_q, mem_we_d;
  // Load context kept for extraction when the data returns
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  // Writeback registers
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  rd_q, rd_d;
  logic        wb_en_q, wb_en_d;

  logic        is_load, is_store, f3_legal, misaligned, capture, mem_ok;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Decode the incoming instruction: class, funct3 legality and alignment
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    is_load    = (i_opcode == OP_LOAD);
    is_store   = (i_opcode == OP_STORE);
    f3_legal   = 1'b0;
    if (is_load) begin
      case (i_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
        default:                                f3_legal = 1'b0;
      endcase
    end else if (is_store) begin
      case (i_funct3)
        3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
        default:                f3_legal = 1'b0;
      endcase
    end
    misaligned = ((i_funct3[1:0] == 2'b01) && i_alu_num[0]) ||
                 ((i_funct3[1:0] == 2'b10) && (i_alu_num[1:0] != 2'b00));
    capture    = (state_q == S_IDLE) && i_valid;
    mem_ok     = capture && (is_load || is_store) && f3_legal && !misaligned;
  end

  // Store byte enables and lane-replicated write data
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = i_store_data;
    case (i_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << i_alu_num[1:0];
        st_wdata = {4{i_store_data[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << i_alu_num[1:0];
        st_wdata = {2{i_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction with sign/zero extension
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = i_mem_rdata[7:0];
      2'd1:    ld_byte = i_mem_rdata[15:8];
      2'd2:    ld_byte = i_mem_rdata[23:16];
      default: ld_byte = i_mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = i_mem_rdata;
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (mem_ok)       state_d = S_REQ;
      S_REQ:   if (i_mem_ready)  state_d = mem_we_q ? S_IDLE : S_WAIT;
      S_WAIT:  if (i_mem_rvalid) state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_mem_req = (state_q == S_REQ);
    o_stall   = (state_q != S_IDLE);
  end

  // Datapath next-state: capture, store completion, load return
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    mem_we_d    = mem_we_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    ld_rd_d     = ld_rd_q;
    valid_d     = 1'b0;
    fault_d     = 1'b0;
    wb_data_d   = wb_data_q;
    rd_d        = rd_q;
    wb_en_d     = wb_en_q;
    case (state_q)
      S_IDLE: begin
        if (mem_ok) begin
          mem_addr_d  = {i_alu_num[31:2], 2'b00};
          mem_be_d    = is_store ? st_be : 4'b1111;
          mem_wdata_d = is_store ? st_wdata : 32'd0;
          mem_we_d    = is_store;
          funct3_d    = i_funct3;
          off_d       = i_alu_num[1:0];
          ld_rd_d     = i_rd;
        end else if (capture && (is_load || is_store)) begin
          valid_d = 1'b1;
          fault_d = 1'b1;
          rd_d    = i_rd;
          wb_en_d = 1'b0;
        end else if (capture) begin
          valid_d   = 1'b1;
          wb_data_d = i_alu_num;
          rd_d      = i_rd;
          wb_en_d   = i_rd_we;
        end
      end
      S_REQ: begin
        if (i_mem_ready && mem_we_q) begin
          valid_d = 1'b1;
          rd_d    = ld_rd_q;
          wb_en_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (i_mem_rvalid) begin
          valid_d   = 1'b1;
          wb_data_d = ld_data;
          rd_d      = ld_rd_q;
          wb_en_d   = (ld_rd_q != 5'd0);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      mem_we_q    <= 1'b0;
      funct3_q    <= '0;
      off_q       <= '0;
      ld_rd_q     <= '0;
      valid_q     <= 1'b0;
      fault_q     <= 1'b0;
      wb_data_q   <= '0;
      rd_q        <= '0;
      wb_en_q     <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      mem_we_q    <= mem_we_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      ld_rd_q     <= ld_rd_d;
      valid_q     <= valid_d;
      fault_q     <= fault_d;
      wb_data_q   <= wb_data_d;
      rd_q        <= rd_d;
      wb_en_q     <= wb_en_d;
    end
  end

  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_be    = mem_be_q;
  assign o_valid     = valid_q;
  assign o_fault     = fault_q;
  assign o_wb_data   = wb_data_q;
  assign o_rd        = rd_q;
  assign o_wb_en     = wb_en_q;

endmodule
